// File: rtl/nibble_word_serializer.sv
// Word-to-nibble serializer: accepts a word over valid/ready and emits one 4-bit nibble
// per beat, LSB-first or MSB-first, reloading on the last beat so words stream gap-free.
module nibble_word_serializer #(
    parameter int unsigned CNT_SIZE = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [4*(2**CNT_SIZE)-1:0]    in_word,
    input  logic                          in_msb_first,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [3:0]                    out_nibble,
    output logic [CNT_SIZE-1:0]           out_idx,
    output logic                          out_first,
    output logic                          out_last,
    output logic                          busy
);

    localparam int unsigned N = 2 ** CNT_SIZE;
    localparam int unsigned W = 4 * N;

    typedef enum logic {StIdle, StSend} state_e;

    state_e              state_q;
    logic [W-1:0]        word_q;
    logic                msb_first_q;
    logic [CNT_SIZE-1:0] cnt_q;

    logic                transfer;
    logic                accept;
    logic [CNT_SIZE-1:0] cnt_next;
    logic [CNT_SIZE-1:0] idx_next;
    logic [CNT_SIZE-1:0] idx_load;

    assign transfer = out_valid & out_ready;
    assign in_ready = ~rst & ((state_q == StIdle) | (transfer & out_last));
    assign accept   = in_valid & in_ready;
    assign busy     = out_valid;

    // MSB-first index is N-1-k, which is simply the bitwise complement of k.
    assign cnt_next = cnt_q + 1'b1;
    assign idx_next = msb_first_q ? ~cnt_next : cnt_next;
    assign idx_load = {CNT_SIZE{in_msb_first}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            word_q      <= '0;
            msb_first_q <= 1'b0;
            cnt_q       <= '0;
            out_valid   <= 1'b0;
            out_nibble  <= 4'h0;
            out_idx     <= '0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
        end else if (accept) begin
            // Covers both a fresh start from idle and a reload on the final beat.
            state_q     <= StSend;
            word_q      <= in_word;
            msb_first_q <= in_msb_first;
            cnt_q       <= '0;
            out_valid   <= 1'b1;
            out_nibble  <= in_word[{idx_load, 2'b00} +: 4];
            out_idx     <= idx_load;
            out_first   <= 1'b1;
            out_last    <= (N == 1);
        end else if (transfer) begin
            if (&cnt_q) begin
                state_q    <= StIdle;
                cnt_q      <= '0;
                out_valid  <= 1'b0;
                out_nibble <= 4'h0;
                out_idx    <= '0;
                out_first  <= 1'b0;
                out_last   <= 1'b0;
            end else begin
                cnt_q      <= cnt_next;
                out_nibble <= word_q[{idx_next, 2'b00} +: 4];
                out_idx    <= idx_next;
                out_first  <= 1'b0;
                out_last   <= &cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_nibble_word_serializer.sv
// Randomized and directed bench for nibble_word_serializer against an arithmetic
// beat-list model of the serialized word.
module tb_nibble_word_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        in_msb_first;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_nibble;
    logic [2:0]  out_idx;
    logic        out_first;
    logic        out_last;
    logic        busy;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [3:0] nib;
        logic [2:0] idx;
        logic       first;
        logic       last;
    } beat_t;

    beat_t q[$];

    always #5 clk = ~clk;

    nibble_word_serializer #(.CNT_SIZE(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
        .in_msb_first (in_msb_first),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_nibble   (out_nibble),
        .out_idx      (out_idx),
        .out_first    (out_first),
        .out_last     (out_last),
        .busy         (busy)
    );

    function automatic logic [3:0] nib_of(input logic [31:0] w, input int idx);
        return 4'((w >> (4 * idx)) & 32'hF);
    endfunction

    // Beat k of a word: which nibble position goes out, by the direction rule.
    function automatic int idx_of(input int k, input logic m);
        return m ? 7 - k : k;
    endfunction

    task automatic model_push(input logic [31:0] w, input logic m);
        for (int k = 0; k < 8; k++) begin
            q.push_back('{nib: nib_of(w, idx_of(k, m)), idx: 3'(idx_of(k, m)),
                          first: (k == 0), last: (k == 7)});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_word = '0; in_msb_first = 1'b0; out_ready = 1'b1;
        #1;
        total++;
        if ({out_valid, busy, out_nibble, out_idx, out_first, out_last} !== 11'd0)
            $display("FAIL reset_outs: got %h required 0",
                     {out_valid, busy, out_nibble, out_idx, out_first, out_last});
        else passed++;
        total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", in_ready);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL post_reset_ready: got %b required 1", in_ready);
        else passed++;
    endtask

    // Sends one word with out_ready held high; expects 8 consecutive beats then idle.
    task automatic test_word(input logic [31:0] w, input logic m);
        int i;
        @(negedge clk);
        in_valid = 1'b1; in_word = w; in_msb_first = m; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL word_accept_ready: got %b required 1", in_ready);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0; in_word = 'x;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            i = idx_of(k, m);
            total++;
            if ({out_valid, out_nibble, out_idx, out_first, out_last} !==
                {1'b1, nib_of(w, i), 3'(i), k == 0, k == 7})
                $display("FAIL word_beat %0d (w=%h m=%b): got v%b n%h i%0d f%b l%b required n%h i%0d",
                         k, w, m, out_valid, out_nibble, out_idx, out_first, out_last,
                         nib_of(w, i), i);
            else passed++;
        end
        @(negedge clk);
        #1;
        total++;
        if ({out_valid, busy, out_nibble, out_idx, out_first, out_last} !== 11'd0)
            $display("FAIL word_idle: got %h required 0",
                     {out_valid, busy, out_nibble, out_idx, out_first, out_last});
        else passed++;
    endtask

    task automatic test_streaming();
        logic [31:0] w1, w2, w;
        int k;
        w1 = 32'hAAAA_0001; w2 = 32'h5555_FFFE;
        @(negedge clk);
        in_valid = 1'b1; in_word = w1; in_msb_first = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_word = w2;
        for (int b = 0; b < 16; b++) begin
            if (b > 0) @(negedge clk);
            if (b == 8) in_valid = 1'b0;
            #1;
            w = (b < 8) ? w1 : w2;
            k = b % 8;
            total++;
            if ({out_valid, out_nibble, out_idx, out_first, out_last} !==
                {1'b1, nib_of(w, k), 3'(k), k == 0, k == 7})
                $display("FAIL stream_beat %0d: got v%b n%h i%0d f%b l%b required n%h i%0d",
                         b, out_valid, out_nibble, out_idx, out_first, out_last, nib_of(w, k), k);
            else passed++;
            total++;
            if (in_ready !== (b == 7 || b == 15))
                $display("FAIL stream_ready %0d: got %b required %b", b, in_ready,
                         (b == 7 || b == 15));
            else passed++;
        end
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL stream_idle: got %b required 0", out_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        int ptr, stalls;
        w = 32'hCAFE_BABE;
        ptr = 0; stalls = 0;
        @(negedge clk);
        in_valid = 1'b1; in_word = w; in_msb_first = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 24 && ptr < 8; c++) begin
            if (c > 0) @(negedge clk);
            out_ready = !(ptr == 3 && stalls < 3);
            if (!out_ready) stalls++;
            #1;
            total++;
            if ({out_valid, out_nibble, out_idx, out_first, out_last} !==
                {1'b1, nib_of(w, ptr), 3'(ptr), ptr == 0, ptr == 7})
                $display("FAIL bp_beat cycle %0d: got v%b n%h i%0d f%b l%b required n%h i%0d",
                         c, out_valid, out_nibble, out_idx, out_first, out_last,
                         nib_of(w, ptr), ptr);
            else passed++;
            if (out_ready) ptr++;
        end
        total++;
        if (ptr != 8) $display("FAIL bp_timeout: got %0d beats required 8", ptr);
        else passed++;
        @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL bp_idle: got %b required 0", out_valid);
        else passed++;
    endtask

    task automatic test_reset_midword();
        @(negedge clk);
        in_valid = 1'b1; in_word = 32'h1234_5678; in_msb_first = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        total++;
        if (out_idx !== 3'd4) $display("FAIL rst_mid_pre: got idx %0d required 4", out_idx);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, busy, out_nibble, out_idx, out_first, out_last, in_ready} !== 12'd0)
            $display("FAIL rst_mid_now: got %h required 0",
                     {out_valid, busy, out_nibble, out_idx, out_first, out_last, in_ready});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_after: got %b required 0", out_valid);
        else passed++;
        test_word(32'h0000_000F, 1'b0);
    endtask

    task automatic test_direction();
        logic [31:0] w;
        int i;
        w = 32'h9ABC_DEF0;
        @(negedge clk);
        in_valid = 1'b1; in_word = w; in_msb_first = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 2) in_msb_first = 1'b1;
            #1;
            total++;
            if ({out_nibble, out_idx} !== {nib_of(w, k), 3'(k)})
                $display("FAIL dir_hold beat %0d: got n%h i%0d required n%h i%0d",
                         k, out_nibble, out_idx, nib_of(w, k), k);
            else passed++;
        end
        // Next word picks up the still-asserted MSB-first direction.
        @(negedge clk);
        w = 32'h1357_9BDF;
        in_valid = 1'b1; in_word = w;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            i = idx_of(k, 1'b1);
            total++;
            if ({out_valid, out_nibble, out_idx} !== {1'b1, nib_of(w, i), 3'(i)})
                $display("FAIL dir_new beat %0d: got v%b n%h i%0d required n%h i%0d",
                         k, out_valid, out_nibble, out_idx, nib_of(w, i), i);
            else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic exp_rdy;
        q.delete();
        for (int c = 0; c < 640; c++) begin
            @(negedge clk);
            if (c < 600) begin
                out_ready    = ($urandom_range(0, 3) != 0);
                in_valid     = ($urandom_range(0, 2) == 0);
                in_word      = in_valid ? 32'($urandom) : 'x;
                in_msb_first = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1; in_valid = 1'b0; in_word = 'x;
            end
            #1;
            exp_rdy = (q.size() == 0) || (out_ready && q.size() == 1);
            total++;
            if (in_ready !== exp_rdy)
                $display("FAIL rnd_ready cycle %0d: got %b required %b", c, in_ready, exp_rdy);
            else passed++;
            total++;
            if (q.size() == 0) begin
                if ({out_valid, busy, out_nibble, out_idx, out_first, out_last} !== 11'd0)
                    $display("FAIL rnd_idle cycle %0d: got %h required 0", c,
                             {out_valid, busy, out_nibble, out_idx, out_first, out_last});
                else passed++;
            end else begin
                if ({out_valid, busy, out_nibble, out_idx, out_first, out_last} !==
                    {2'b11, q[0].nib, q[0].idx, q[0].first, q[0].last})
                    $display("FAIL rnd_beat cycle %0d: got v%b n%h i%0d f%b l%b required n%h i%0d f%b l%b",
                             c, out_valid, out_nibble, out_idx, out_first, out_last,
                             q[0].nib, q[0].idx, q[0].first, q[0].last);
                else passed++;
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && exp_rdy) model_push(in_word, in_msb_first);
        end
        total++;
        if (q.size() != 0) $display("FAIL rnd_drain: got %0d beats pending required 0", q.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_word(32'h1234_5678, 1'b0);
        test_word(32'h1234_5678, 1'b1);
        test_streaming();
        test_backpressure();
        test_reset_midword();
        test_direction();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
